// File: rtl/axi_lite_sram.sv
`timescale 1ns/1ps
// AXI4-Lite slave backed by a DEPTH x DWIDTH word array, with an independent write FSM and read FSM.
// Latency: the write commits once both the AW and W beats are held, and B follows on the next cycle. RVALID rises RD_LAT cycles after the AR handshake.
// Backpressure: each READY drops after its beat is captured. B and R hold stable until BREADY/RREADY. At most one read and one write are in flight.
// Ports: clk/resetn (sync, active-low); AW*, W*, B* write channels; AR*, R* read channels.
module axi_lite_sram #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 64,
  parameter int                DEPTH     = 1024,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h8000_0000),
  parameter int                RD_LAT    = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [AWIDTH-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DWIDTH-1:0]   WDATA,
  input  logic [DWIDTH/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [AWIDTH-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DWIDTH-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY
);
  localparam int NBYTES = DWIDTH / 8;
  localparam int OFFS   = $clog2(NBYTES);
  localparam int IW     = $clog2(DEPTH);
  localparam logic [AWIDTH:0] SPAN = (AWIDTH+1)'(DEPTH * NBYTES);
  // R_WAIT counts down to zero, so RD_LAT-2 in the counter gives RD_LAT total cycles.
  localparam logic [2:0] CNT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  typedef enum logic       {W_IDLE, W_RESP}         wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

  function automatic logic addr_hit(input logic [AWIDTH-1:0] a);
    return (a >= BASE_ADDR) && ((AWIDTH+1)'(a - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [AWIDTH-1:0] a);
    return IW'((a - BASE_ADDR) >> OFFS);
  endfunction

  logic [DWIDTH-1:0] mem [DEPTH];

  // ---------------- write path ----------------
  wstate_t           w_state;
  logic              aw_held, w_held;
  logic [AWIDTH-1:0] aw_addr_q;
  logic [DWIDTH-1:0] w_data_q;
  logic [NBYTES-1:0] w_strb_q;

  logic              aw_fire, w_fire, commit, wr_hit;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic [NBYTES-1:0] wr_strb;

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  // A beat arriving this cycle is used directly, so the commit needs no extra cycle.
  assign wr_addr = aw_held ? aw_addr_q : AWADDR;
  assign wr_data = w_held  ? w_data_q  : WDATA;
  assign wr_strb = w_held  ? w_strb_q  : WSTRB;
  assign commit  = resetn && (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  assign wr_hit  = addr_hit(wr_addr);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      AWREADY <= 1'b1;
      WREADY  <= 1'b1;
      BVALID  <= 1'b0;
      BRESP   <= 2'b00;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_addr_q <= AWADDR;
            aw_held   <= 1'b1;
            AWREADY   <= 1'b0;
          end
          if (w_fire) begin
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
            w_held   <= 1'b1;
            WREADY   <= 1'b0;
          end
          if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= wr_hit ? 2'b00 : 2'b11;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit && wr_hit) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_strb[i]) mem[word_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rstate_t           r_state;
  logic [2:0]        cnt;
  logic [DWIDTH-1:0] rd_buf;
  logic [1:0]        rresp_buf;
  logic              rd_hit;
  logic [DWIDTH-1:0] rd_word;

  // The array is sampled before this edge's write lands, so a same-cycle write stays invisible.
  assign rd_hit  = addr_hit(ARADDR);
  assign rd_word = rd_hit ? mem[word_idx(ARADDR)] : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= 2'b00;
      cnt     <= 3'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            ARREADY <= 1'b0;
            if (RD_LAT == 1) begin
              RDATA   <= rd_word;
              RRESP   <= rd_hit ? 2'b00 : 2'b11;
              RVALID  <= 1'b1;
              r_state <= R_DATA;
            end else begin
              rd_buf    <= rd_word;
              rresp_buf <= rd_hit ? 2'b00 : 2'b11;
              cnt       <= CNT_INIT;
              r_state   <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (cnt == 3'd0) begin
            RDATA   <= rd_buf;
            RRESP   <= rresp_buf;
            RVALID  <= 1'b1;
            r_state <= R_DATA;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_sram.sv
`timescale 1ns/1ps
module tb_axi_lite_sram;
  localparam int          DEPTH  = 16;
  localparam int          RD_LAT = 3;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] TOP    = BASE + DEPTH * 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [63:0] WDATA, RDATA;
  logic [7:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  axi_lite_sram #(.AWIDTH(32), .DWIDTH(64), .DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic [63:0] data; logic [1:0] resp;} rexp_t;

  int          compared = 0, mismatched = 0;
  int          b_seen = 0, r_seen = 0;
  int          rdy_mode = 1;   // 0 random, 1 always ready, 2 RREADY held low
  logic [63:0] model [DEPTH];
  rexp_t       exp_r [$];
  logic [1:0]  exp_b [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < TOP);
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) / 8);
  endfunction

  // ch: 0 AW, 1 W, 2 AR. Holds VALID from the current negedge until the handshake edge has passed.
  task automatic wait_rdy(input int ch);
    int n = 0;
    while (!(ch == 0 ? AWREADY : ch == 1 ? WREADY : ARREADY) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout(ch == 0 ? "awready" : ch == 1 ? "wready" : "arready");
    @(negedge clk);
  endtask

  task automatic wait_seen(input bit is_r, input int target);
    int n = 0;
    while ((is_r ? r_seen : b_seen) < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout(is_r ? "r_response" : "b_response");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int da, input int dw);
    int target = b_seen + 1;
    if (in_rng(a)) begin
      exp_b.push_back(2'b00);
      for (int i = 0; i < 8; i++) if (s[i]) model[idx(a)][8*i +: 8] = d[8*i +: 8];
    end else begin
      exp_b.push_back(2'b11);
    end
    @(negedge clk);
    fork
      begin
        repeat (da) @(negedge clk);
        AWADDR = a; AWVALID = 1'b1;
        wait_rdy(0);
        AWVALID = 1'b0;
      end
      begin
        repeat (dw) @(negedge clk);
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        wait_rdy(1);
        WVALID = 1'b0;
      end
    join
    wait_seen(1'b0, target);
  endtask

  task automatic do_read(input logic [31:0] a, input int dl);
    rexp_t e;
    int target = r_seen + 1;
    e.data = in_rng(a) ? model[idx(a)] : 64'h0;
    e.resp = in_rng(a) ? 2'b00 : 2'b11;
    exp_r.push_back(e);
    @(negedge clk);
    repeat (dl) @(negedge clk);
    ARADDR = a; ARVALID = 1'b1;
    wait_rdy(2);
    ARVALID = 1'b0;
    wait_seen(1'b1, target);
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) return 32'h7FFF_FFF8 - 32'(8 * $urandom_range(0, 3));
    if (r == 1) return TOP + 32'($urandom_range(0, 40));
    return BASE + 32'(8 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 7));
  endfunction

  // Ready generator.
  initial begin
    BREADY = 1'b1; RREADY = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       begin BREADY = 1'($urandom_range(0, 1)); RREADY = 1'($urandom_range(0, 1)); end
        2:       begin BREADY = 1'b1; RREADY = 1'b0; end
        default: begin BREADY = 1'b1; RREADY = 1'b1; end
      endcase
    end
  end

  // Monitor: pops expected responses on each handshake, checks latency and hold rules.
  initial begin
    logic        pv = 1'b0, pr = 1'b0, pbv = 1'b0, pbr = 1'b0;
    logic [63:0] pd = '0;
    logic [1:0]  presp = '0, pbresp = '0;
    bit          pend = 1'b0;
    longint      arc = 0;
    rexp_t       e;
    logic [1:0]  eb;
    forever begin
      @(negedge clk);
      #1;
      if (!resetn) begin
        pv = 1'b0; pbv = 1'b0; pend = 1'b0;
        continue;
      end
      if (pend) chk("arready_while_busy", ARREADY, 0);
      if (ARVALID && ARREADY) begin pend = 1'b1; arc = cyc; end
      if (RVALID && !pv) chk("rd_latency", cyc - arc, RD_LAT);
      if (pv && !pr) begin
        chk("rvalid_hold", RVALID, 1);
        chk("rdata_hold", RDATA, pd);
        chk("rresp_hold", RRESP, presp);
      end
      if (RVALID && RREADY) begin
        if (exp_r.size() == 0) timeout("unexpected_r");
        else begin
          e = exp_r.pop_front();
          chk("rdata", RDATA, e.data);
          chk("rresp", RRESP, e.resp);
        end
        r_seen++;
        pend = 1'b0;
      end
      if (pbv && !pbr) begin
        chk("bvalid_hold", BVALID, 1);
        chk("bresp_hold", BRESP, pbresp);
      end
      if (BVALID && BREADY) begin
        if (exp_b.size() == 0) timeout("unexpected_b");
        else begin
          eb = exp_b.pop_front();
          chk("bresp", BRESP, eb);
        end
        b_seen++;
      end
      pv = RVALID; pr = RREADY; pd = RDATA; presp = RRESP;
      pbv = BVALID; pbr = BREADY; pbresp = BRESP;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wa, ra;
    rexp_t       e;
    int          tb_, tr_;
    resetn = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    ARADDR = '0; ARVALID = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", AWREADY, 1);
    chk("rst_wready",  WREADY,  1);
    chk("rst_arready", ARREADY, 1);
    chk("rst_bvalid",  BVALID,  0);
    chk("rst_rvalid",  RVALID,  0);
    chk("rst_bresp",   BRESP,   0);
    chk("rst_rresp",   RRESP,   0);
    chk("rst_rdata",   RDATA,   0);
    resetn = 1'b1;

    for (int i = 0; i < DEPTH; i++) do_write(BASE + 32'(8 * i), {$urandom, $urandom}, 8'hFF, 0, 0);

    // AW first, W two cycles later, then read back.
    do_write(32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 0, 2);
    do_read(32'h8000_0008, 0);

    // Partial strobe merge.
    do_write(32'h8000_0020, 64'h0102_0304_0506_0708, 8'hFF, 0, 0);
    do_write(32'h8000_0020, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1, 0);
    do_read(32'h8000_0020, 0);

    // Slow RREADY: data must stay put and AR must stay closed.
    rdy_mode = 2;
    fork
      do_read(BASE, 0);
      begin repeat (RD_LAT + 7) @(negedge clk); rdy_mode = 1; end
    join

    // Decode errors on both sides; word 0 must not be aliased by the write.
    do_read(32'h7FFF_FFF8, 0);
    do_write(TOP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
    do_read(BASE, 0);
    do_read(TOP - 8, 0);
    do_read(TOP, 0);

    // Read sampled in the same cycle as a write commit to that word sees old data.
    do_write(32'h8000_0010, 64'h5, 8'hFF, 0, 0);
    @(negedge clk);
    e.data = model[2]; e.resp = 2'b00;
    exp_r.push_back(e);
    exp_b.push_back(2'b00);
    model[2] = 64'h9;
    tb_ = b_seen + 1; tr_ = r_seen + 1;
    chk("same_cycle_awready", AWREADY, 1);
    chk("same_cycle_wready",  WREADY,  1);
    chk("same_cycle_arready", ARREADY, 1);
    AWADDR = 32'h8000_0010; AWVALID = 1'b1; WDATA = 64'h9; WSTRB = 8'hFF; WVALID = 1'b1;
    ARADDR = 32'h8000_0010; ARVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    wait_seen(1'b0, tb_);
    wait_seen(1'b1, tr_);
    do_read(32'h8000_0010, 0);

    // Reset after AW capture but before W: write abandoned.
    @(negedge clk);
    AWADDR = 32'h8000_0018; AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("abort_awready", AWREADY, 1);
    chk("abort_wready",  WREADY,  1);
    chk("abort_bvalid",  BVALID,  0);
    do_read(32'h8000_0018, 0);

    // Randomized traffic with random backpressure.
    rdy_mode = 0;
    for (int it = 0; it < 250; it++) begin
      int op = $urandom_range(0, 2);
      wa = rand_addr();
      ra = rand_addr();
      if (op == 0) begin
        do_write(wa, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      end else if (op == 1) begin
        do_read(ra, $urandom_range(0, 2));
      end else begin
        if (in_rng(wa) && in_rng(ra) && idx(wa) == idx(ra)) ra = ra ^ 32'h8;
        fork
          do_write(wa, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
          do_read(ra, $urandom_range(0, 3));
        join
      end
    end
    rdy_mode = 1;
    repeat (5) @(negedge clk);
    chk("pending_r_left", 64'(exp_r.size()), 0);
    chk("pending_b_left", 64'(exp_b.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/axi_lite_sram.md
AXI_LITE_SRAM -- requirements
Module: axi_lite_sram

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width in bits.
REQ-002 SHALL have parameter DWIDTH, default 64, data width; legal values 32 or 64.
REQ-003 SHALL have parameter DEPTH, default 1024, number of DWIDTH-bit words; power of two.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0; aligned to DEPTH*DWIDTH/8.
REQ-005 SHALL have parameter RD_LAT, default 1, cycles from AR handshake to RVALID; legal range 1..8.
REQ-006 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-007 SHALL have port resetn, input, 1, reset, synchronous, active-low.
REQ-008 SHALL have ports AWADDR/AWVALID/AWREADY, in/in/out, AWIDTH/1/1, write address channel.
REQ-009 SHALL have ports WDATA/WSTRB/WVALID/WREADY, in/in/in/out, DWIDTH/DWIDTH/8/1/1, write data channel.
REQ-010 SHALL have ports BRESP/BVALID/BREADY, out/out/in, 2/1/1, write response channel.
REQ-011 SHALL have ports ARADDR/ARVALID/ARREADY, in/in/out, AWIDTH/1/1, read address channel.
REQ-012 SHALL have ports RDATA/RRESP/RVALID/RREADY, out/out/out/in, DWIDTH/2/1/1, read data channel.

Function
REQ-013 SHALL hold storage in an internal DEPTH x DWIDTH array; word index = (addr - BASE_ADDR) >> log2(DWIDTH/8); low byte-offset bits ignored.
REQ-014 SHALL treat any address outside [BASE_ADDR, BASE_ADDR + DEPTH*DWIDTH/8) as a decode error: no array access, RESP = 2'b11.
REQ-015 SHALL respond RESP = 2'b00 for every in-range access; 2'b01/2'b10 never generated.
REQ-016 Write FSM SHALL have states W_IDLE, W_RESP.
REQ-017 In W_IDLE, AWREADY SHALL be 1 until an AW beat is captured, WREADY 1 until a W beat is captured; AW and W accepted in either order or same cycle.
REQ-018 A captured beat SHALL drop its READY until the next return to W_IDLE; second beat of the same channel never accepted early.
REQ-019 In the cycle both beats are held (captured this cycle or earlier), the write SHALL commit: byte i written iff WSTRB[i]; then go W_RESP.
REQ-020 In W_RESP, BVALID SHALL be 1 and BRESP stable until BVALID&BREADY; then W_IDLE with AWREADY=WREADY=1 the next cycle.
REQ-021 Read FSM SHALL have states R_IDLE, R_WAIT, R_DATA; ARREADY = 1 only in R_IDLE.
REQ-022 On AR handshake, address SHALL be latched; RVALID asserts exactly RD_LAT cycles later (RD_LAT=1: next cycle, R_WAIT skipped) via a down-counter in R_WAIT.
REQ-023 In R_DATA, RVALID=1 with RDATA/RRESP stable until RVALID&RREADY; then R_IDLE, ARREADY=1 next cycle; one read outstanding at most.
REQ-024 Decode-error read SHALL return RDATA = 0.
REQ-025 Array SHALL be sampled in the cycle of the AR handshake; a write committing the same cycle to the same word SHALL NOT be visible to that read (old data returned).
REQ-026 Read and write paths SHALL operate fully independently and concurrently.

Reset
REQ-027 While resetn=0 at a clock edge: AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, FSMs to W_IDLE/R_IDLE, captured beats and counter cleared.
REQ-028 Reset mid-transaction SHALL abandon it; a write not yet committed SHALL NOT occur; array contents unaffected by reset (simulation init to zero).

Verification
REQ-029 AW 0x8000_0008 then W 0x1122334455667788 two cycles later, WSTRB=0xFF, BREADY=1 -> one BVALID pulse, BRESP=00; read 0x8000_0008 -> RDATA=0x1122334455667788 after RD_LAT cycles.
REQ-030 WSTRB=0x0F write 0xAAAAAAAAAAAAAAAA over word 0x0102030405060708 -> read returns 0x01020304AAAAAAAA.
REQ-031 RD_LAT=3, AR 0x8000_0000 with RREADY held low 5 cycles -> RVALID rises 3 cycles after handshake, data stable, ARREADY=0 until R handshake.
REQ-032 AR 0x7FFF_FFF8 and AW 0x8000_0000+DEPTH*8 -> RRESP=11, RDATA=0, BRESP=11, array unchanged.
REQ-033 Same-cycle AR handshake and write commit to word 0x8000_0010 (old 0x5, new 0x9) -> read returns 0x5; subsequent read returns 0x9.
REQ-034 resetn=0 one cycle after AW captured, before W -> after reset AWREADY=WREADY=1, BVALID=0, target word unchanged.
